word_packer: RTL
================

# word_packer

Downstream of the lane-compaction filter in the SSSP update path. Takes up to four compacted 64-bit words per cycle (valid lanes contiguous from lane 0), accumulates them in arrival order, and emits dense four-word lines for the memory writer. On end of stream it flushes the residual partial line with a lane mask and signals completion.

## Interface
- WORD_W, 64, width of one word
- CNT_W, 32, width of the word and line statistics counters
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- last_input_in  in  1  end-of-stream level from the filter, stays high after the final beat
- word_in_valid  in  4  per-lane valid; legal patterns are 0000, 0001, 0011, 0111, 1111
- word_in  in  4 x WORD_W  input words; lane 0 is oldest
- line_out_valid  out  1  one line presented this cycle
- line_out  out  4 x WORD_W  packed line; lane 0 is oldest
- line_out_mask  out  4  valid lanes of line_out; 1111 except on the flush line
- last_output  out  1  single-cycle pulse marking end of stream
- proto_err  out  1  sticky protocol-violation flag
- word_count  out  CNT_W  words accepted since reset, wraps modulo 2^CNT_W
- line_count  out  CNT_W  lines emitted, partial line included; wraps

## Operation
- State: residual buffer of 3 words plus a 2-bit occupancy `k` (0-3). FSM states RUN, FLUSH, DONE.
- RUN, per cycle: `n` = popcount(word_in_valid). The combined sequence is the buffer (k words), then input lanes 0..n-1.
  - If k+n >= 4, the first 4 words form the output line (mask 1111) and the remaining k+n-4 words (0-3) become the new buffer.
  - Otherwise all words go to the buffer and no line is emitted.
  - Since k+n <= 7, at most one line per cycle is emitted and the buffer never overflows.
- RUN with last_input_in=1: perform the normal RUN step for this cycle's inputs.
  - If the resulting residual > 0: go to FLUSH.
  - If the resulting residual = 0: go to DONE and raise last_output together with this step's output. If no line is emitted, last_output rises alone with line_out_valid=0.
- FLUSH (one cycle, inputs ignored): emit the residual as a line with mask = thermometer(k), unused lanes zero. Raise last_output, clear k, go to DONE.
- DONE: hold until last_input_in=0, then go to RUN. Any nonzero word_in_valid in FLUSH or DONE: words dropped, proto_err set.
- Non-thermometer word_in_valid in RUN: proto_err set and the beat is still packed using the valid lanes in lane order (compact-by-popcount).
- proto_err clears only on reset.
- word_count adds n for every accepted beat. line_count increments on each line_out_valid.

## Timing
- All outputs are registered. Input at edge t appears at the outputs after edge t+1 (latency 1).
- A flush line appears one cycle after the line/step carrying the last_input_in beat.
- line_out and line_out_mask are zero whenever line_out_valid=0.
- No backpressure: the consumer must accept one line every cycle.
- Reset (asynchronous assert, any state, including mid-flush): every output is 0, k=0, buffer cleared, FSM=RUN, counters 0. A partial line in flight is discarded.
- Reset deassertion takes effect at the next rising edge.
- last_input_in held high from reset release: the first RUN cycle triggers the flush path. With an empty buffer this is a lone last_output pulse, then DONE.

## Test plan
- Four beats of valid 1111 with words A0..A3, B0..B3, and so on -> four lines, one per cycle starting at t+1, mask 1111, order preserved. word_count=16, line_count=4.
- Beats 0111 (A,B,C), 0011 (D,E), 0111 (F,G,H):
  - no line after the first beat;
  - line A,B,C,D after the second beat, with E buffered;
  - line E,F,G,H after the third beat, k=0.
- 0011 (X,Y) then 0001 (Z) with last_input_in=1 -> line X,Y,Z,0 with mask 0111 and last_output=1 one cycle later (FLUSH), then DONE.
- 1111 beat with last_input_in=1 and k=0 -> the full line and last_output in the same cycle. No FLUSH cycle follows.
- In DONE, drive 0011 -> no line, proto_err=1 and stays 1. Then drop last_input_in and send 1111 -> normal line, proto_err still 1.
- Buffer k=3, assert rst low mid-cycle -> all outputs 0 immediately. After release, 0001 then 0111 -> first line contains only post-reset words.

Source files
------------

// File: rtl/word_packer.sv
// Packs contiguous 64-bit input lanes into dense four-word lines, flushing a masked partial line at end of stream.
// Latency: 1 cycle, every output is registered.
// Backpressure: none; the consumer must take one line per cycle and input beats are never stalled.
module word_packer #(
    parameter int WORD_W = 64,
    parameter int CNT_W  = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   last_input_in,
    input  logic [3:0]             word_in_valid,
    input  logic [3:0][WORD_W-1:0] word_in,
    output logic                   line_out_valid,
    output logic [3:0][WORD_W-1:0] line_out,
    output logic [3:0]             line_out_mask,
    output logic                   last_output,
    output logic                   proto_err,
    output logic [CNT_W-1:0]       word_count,
    output logic [CNT_W-1:0]       line_count
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        FLUSH = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t state_q, state_d;

    // Residual words; slots at and above k_q are always kept zero so they can
    // be laid straight into the combined sequence.
    logic [WORD_W-1:0] res_q [3];
    logic [WORD_W-1:0] res_d [3];
    logic [1:0]        k_q, k_d;

    logic [WORD_W-1:0] cmp  [4];
    logic [WORD_W-1:0] comb [8];
    logic [2:0]        n;
    logic [2:0]        total;
    logic              legal;

    logic                   lv_d;
    logic [3:0][WORD_W-1:0] line_d;
    logic [3:0]             mask_d;
    logic                   last_d;
    logic                   err_d;
    logic [CNT_W-1:0]       wc_d;
    logic [CNT_W-1:0]       lc_d;

    // Compact the valid lanes in lane order; this also covers illegal gappy patterns.
    always_comb begin
        n = 3'd0;
        for (int j = 0; j < 4; j++) cmp[j] = '0;
        for (int j = 0; j < 4; j++) begin
            if (word_in_valid[j]) begin
                cmp[n[1:0]] = word_in[j];
                n = n + 3'd1;
            end
        end
    end

    // Combined sequence: residual words first, then this beat's compacted words.
    always_comb begin
        for (int i = 0; i < 8; i++) comb[i] = '0;
        for (int i = 0; i < 3; i++) comb[i] = res_q[i];
        for (int j = 0; j < 4; j++) begin
            if (3'(j) < n) comb[{1'b0, k_q} + 3'(j)] = cmp[j];
        end
        total = {1'b0, k_q} + n;
        legal = (word_in_valid == 4'b0000) || (word_in_valid == 4'b0001) ||
                (word_in_valid == 4'b0011) || (word_in_valid == 4'b0111) ||
                (word_in_valid == 4'b1111);
    end

    // Next state and next registered outputs.
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        for (int i = 0; i < 3; i++) res_d[i] = res_q[i];
        lv_d    = 1'b0;
        line_d  = '0;
        mask_d  = 4'b0000;
        last_d  = 1'b0;
        err_d   = proto_err;
        wc_d    = word_count;
        lc_d    = line_count;

        case (state_q)
            RUN: begin
                if (!legal) err_d = 1'b1;
                wc_d = word_count + CNT_W'(n);
                if (total >= 3'd4) begin
                    lv_d   = 1'b1;
                    mask_d = 4'b1111;
                    for (int i = 0; i < 4; i++) line_d[i] = comb[i];
                    for (int i = 0; i < 3; i++) res_d[i] = comb[i+4];
                    k_d = 2'(total - 3'd4);
                end else begin
                    for (int i = 0; i < 3; i++) res_d[i] = comb[i];
                    k_d = 2'(total);
                end
                if (last_input_in) begin
                    if (k_d != 2'd0) begin
                        state_d = FLUSH;
                    end else begin
                        state_d = DONE;
                        last_d  = 1'b1;
                    end
                end
            end
            FLUSH: begin
                if (word_in_valid != 4'b0000) err_d = 1'b1;
                lv_d   = 1'b1;
                last_d = 1'b1;
                for (int i = 0; i < 3; i++) line_d[i] = res_q[i];
                case (k_q)
                    2'd1:    mask_d = 4'b0001;
                    2'd2:    mask_d = 4'b0011;
                    2'd3:    mask_d = 4'b0111;
                    default: mask_d = 4'b0000;
                endcase
                for (int i = 0; i < 3; i++) res_d[i] = '0;
                k_d     = 2'd0;
                state_d = DONE;
            end
            default: begin
                if (word_in_valid != 4'b0000) err_d = 1'b1;
                if (!last_input_in) state_d = RUN;
            end
        endcase

        if (lv_d) lc_d = line_count + CNT_W'(1);
    end

    // State, residual buffer and all output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= RUN;
            k_q            <= 2'd0;
            for (int i = 0; i < 3; i++) res_q[i] <= '0;
            line_out_valid <= 1'b0;
            line_out       <= '0;
            line_out_mask  <= 4'b0000;
            last_output    <= 1'b0;
            proto_err      <= 1'b0;
            word_count     <= '0;
            line_count     <= '0;
        end else begin
            state_q        <= state_d;
            k_q            <= k_d;
            for (int i = 0; i < 3; i++) res_q[i] <= res_d[i];
            line_out_valid <= lv_d;
            line_out       <= line_d;
            line_out_mask  <= mask_d;
            last_output    <= last_d;
            proto_err      <= err_d;
            word_count     <= wc_d;
            line_count     <= lc_d;
        end
    end

endmodule
